// File: rtl/addsub_slice_seq.sv
`default_nettype none
// ============================================================================
// Module   : addsub_slice_seq
// Function : Multi-cycle WIDTH-bit adder/subtractor, one SLICE-bit slice per
//            clock (LSB first), valid/ready handshake and result flags.
// Revision : 1.0
// ============================================================================
module addsub_slice_seq #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic             add_sub_sel,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             c_out,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    localparam logic [CW-1:0] c_last_slice = CW'(NSLICE - 1);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_run  = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    generate
        if ((SLICE < 1) || (SLICE > WIDTH) || ((WIDTH % SLICE) != 0)) begin : g_bad_params
            $error("addsub_slice_seq: WIDTH must be a non-zero multiple of SLICE");
        end
    endgenerate

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [CW-1:0]    r_k;
    logic             r_carry;
    logic             r_sub;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_out;
    logic             r_c_out;
    logic             r_ovf;
    logic             r_zero;
    logic             r_neg;

    logic [SLICE-1:0] w_a_slice;
    logic [SLICE-1:0] w_b_slice;
    logic [SLICE-1:0] w_b_eff;
    logic [SLICE:0]   w_sum_full;
    logic [SLICE-1:0] w_sum;
    logic             w_msb_cin;
    logic             w_last;
    logic             w_accept;
    logic [WIDTH-1:0] w_out_next;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_idle:  if (in_valid) w_state_next = c_run;
            c_run:   if (w_last)   w_state_next = c_done;
            c_done:  if (out_ready) w_state_next = c_idle;
            default: w_state_next = c_idle;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            c_idle:  in_ready  = 1'b1;
            c_done:  out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    assign w_accept = in_valid && (r_state == c_idle);
    assign w_last   = (r_k == c_last_slice);

    // Select the operand slice addressed by the slice counter.
    always_comb begin
        w_a_slice = '0;
        w_b_slice = '0;
        for (int i = 0; i < NSLICE; i++) begin
            if (r_k == CW'(i)) begin
                w_a_slice = r_a[i*SLICE +: SLICE];
                w_b_slice = r_b[i*SLICE +: SLICE];
            end
        end
    end

    assign w_b_eff    = r_sub ? ~w_b_slice : w_b_slice;
    assign w_sum_full = {1'b0, w_a_slice} + {1'b0, w_b_eff} + {{SLICE{1'b0}}, r_carry};
    assign w_sum      = w_sum_full[SLICE-1:0];
    // Carry entering the top bit of this slice; only meaningful on the last slice.
    assign w_msb_cin  = w_a_slice[SLICE-1] ^ w_b_eff[SLICE-1] ^ w_sum[SLICE-1];

    // Full result with the current slice merged in, so zero covers all WIDTH bits.
    always_comb begin
        w_out_next = r_out;
        for (int i = 0; i < NSLICE; i++) begin
            if (r_k == CW'(i)) begin
                w_out_next[i*SLICE +: SLICE] = w_sum;
            end
        end
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_k     <= '0;
            r_carry <= 1'b0;
            r_sub   <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_out   <= '0;
            r_c_out <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
            r_neg   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= inA;
            r_b     <= inB;
            r_sub   <= add_sub_sel;
            r_carry <= add_sub_sel ? ~c_in : c_in;
            r_k     <= '0;
        end else if (r_state == c_run) begin
            r_out   <= w_out_next;
            r_carry <= w_sum_full[SLICE];
            if (w_last) begin
                r_c_out <= w_sum_full[SLICE];
                r_ovf   <= w_msb_cin ^ w_sum_full[SLICE];
                r_zero  <= (w_out_next == '0);
                r_neg   <= w_sum[SLICE-1];
            end else begin
                r_k <= r_k + CW'(1);
            end
        end
    end

    assign out   = r_out;
    assign c_out = r_c_out;
    assign ovf   = r_ovf;
    assign zero  = r_zero;
    assign neg   = r_neg;

endmodule
`default_nettype wire

// File: tb/tb_addsub_slice_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_addsub_slice_seq
// Function : Self-checking bench for addsub_slice_seq at SLICE = 4, 1, 8, 16.
// Revision : 1.0
// ============================================================================
module tb_addsub_slice_seq;

    localparam int WIDTH = 16;
    localparam int NDUT  = 4;
    localparam int SL [NDUT] = '{4, 1, 8, 16};

    typedef struct packed {
        logic [15:0] res;
        logic        co;
        logic        ov;
        logic        z;
        logic        n;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             in_valid  [NDUT];
    logic             in_ready  [NDUT];
    logic [WIDTH-1:0] in_a      [NDUT];
    logic [WIDTH-1:0] in_b      [NDUT];
    logic             sel       [NDUT];
    logic             cin       [NDUT];
    logic             out_valid [NDUT];
    logic             out_ready [NDUT];
    logic [WIDTH-1:0] dout      [NDUT];
    logic             c_out_w   [NDUT];
    logic             ovf_w     [NDUT];
    logic             zero_w    [NDUT];
    logic             neg_w     [NDUT];

    generate
        for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
            addsub_slice_seq #(.WIDTH(WIDTH), .SLICE(SL[gi])) u_dut (
                .clk         (clk),
                .rst         (rst),
                .in_valid    (in_valid[gi]),
                .in_ready    (in_ready[gi]),
                .inA         (in_a[gi]),
                .inB         (in_b[gi]),
                .add_sub_sel (sel[gi]),
                .c_in        (cin[gi]),
                .out_valid   (out_valid[gi]),
                .out_ready   (out_ready[gi]),
                .out         (dout[gi]),
                .c_out       (c_out_w[gi]),
                .ovf         (ovf_w[gi]),
                .zero        (zero_w[gi]),
                .neg         (neg_w[gi])
            );
        end
    endgenerate

    int   checks = 0;
    int   errors = 0;
    res_t exp_r   [NDUT];
    bit   pending [NDUT];
    int   acc_n   [NDUT];
    int   acc_cyc [NDUT];
    int   cyc = 0;

    // Reference: true integer arithmetic, result is its low 16 bits.
    function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic sub, input logic ci);
        res_t   r;
        longint t;
        int     ua;
        int     ub;
        ua = int'(a);
        ub = int'(b);
        if (!sub) begin
            t    = longint'($signed(a)) + longint'($signed(b)) + longint'(ci);
            r.co = ((ua + ub + int'(ci)) > 65535);
        end else begin
            t    = longint'($signed(a)) - longint'($signed(b)) - longint'(ci);
            r.co = (ua >= ub + int'(ci));
        end
        r.res = t[15:0];
        r.ov  = (t > 32767) || (t < -32768);
        r.z   = (r.res == 16'h0000);
        r.n   = r.res[15];
        return r;
    endfunction

    function automatic int nsl(input int i);
        return WIDTH / SL[i];
    endfunction

    function automatic res_t dut_res(input int i);
        return {dout[i], c_out_w[i], ovf_w[i], zero_w[i], neg_w[i]};
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s dut%0d: got %h expected %h", name, idx, act, expv);
        end
    endtask

    // Scoreboard update: capture the command at acceptance, retire at handshake.
    always @(posedge clk) begin
        for (int i = 0; i < NDUT; i++) begin
            if (rst) begin
                pending[i] = 1'b0;
            end else begin
                if (in_valid[i] && in_ready[i]) begin
                    exp_r[i]   = model(in_a[i], in_b[i], sel[i], cin[i]);
                    pending[i] = 1'b1;
                    acc_n[i]   = acc_n[i] + 1;
                    acc_cyc[i] = cyc;
                end
                if (out_valid[i] && out_ready[i]) pending[i] = 1'b0;
            end
        end
        cyc = cyc + 1;
    end

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            for (int i = 0; i < NDUT; i++) begin
                if (out_valid[i]) begin
                    if (!pending[i]) chk("unexpected_valid", i, 32'(out_valid[i]), 32'd0);
                    else             chk("result", i, 32'(dut_res(i)), 32'(exp_r[i]));
                end
            end
        end
    endtask

    task automatic run_op(input int i, input logic [15:0] a, input logic [15:0] b,
                          input logic sub, input logic ci, input int hold,
                          input bit poke, input bit use_lit, input logic [19:0] lit);
        int lat;
        @(negedge clk);
        in_a[i] = a; in_b[i] = b; sel[i] = sub; cin[i] = ci; in_valid[i] = 1'b1;
        lat = 0;
        while (!in_ready[i] && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("accept_ready", i, 32'(in_ready[i]), 32'd1);
        if (!in_ready[i]) begin
            in_valid[i] = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid[i] = 1'b0;
        if (poke) begin
            in_a[i] = ~a; in_b[i] = a; sel[i] = ~sub; cin[i] = ~ci;
            out_ready[i] = 1'b1;
        end
        lat = 0;
        while (!out_valid[i] && lat < 100) begin
            @(negedge clk);
            lat++;
            if (poke && lat == 1) out_ready[i] = 1'b0;
        end
        chk("latency", i, 32'(lat), 32'(nsl(i)));
        chk("busy_in_done", i, 32'(in_ready[i]), 32'd0);
        if (use_lit) chk("literal", i, 32'(dut_res(i)), 32'(lit));
        repeat (hold) begin
            @(negedge clk);
            chk("held_valid", i, 32'(out_valid[i]), 32'd1);
            chk("held_busy", i, 32'(in_ready[i]), 32'd0);
        end
        out_ready[i] = 1'b1;
        @(negedge clk);
        out_ready[i] = 1'b0;
        chk("released", i, 32'({out_valid[i], in_ready[i]}), 32'd1);
    endtask

    task automatic wait_acc(input int i, input int target);
        int lat;
        lat = 0;
        while (acc_n[i] < target && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("b2b_accept", i, 32'(acc_n[i]), 32'(target));
    endtask

    task automatic b2b(input int i);
        int n0;
        int t0;
        int lat;
        @(negedge clk);
        out_ready[i] = 1'b1;
        n0 = acc_n[i];
        in_a[i] = 16'h1111; in_b[i] = 16'h2222; sel[i] = 1'b0; cin[i] = 1'b1;
        in_valid[i] = 1'b1;
        wait_acc(i, n0 + 1);
        t0 = acc_cyc[i];
        in_a[i] = 16'hA000; in_b[i] = 16'h0B00; sel[i] = 1'b1; cin[i] = 1'b0;
        wait_acc(i, n0 + 2);
        in_valid[i] = 1'b0;
        chk("b2b_spacing", i, 32'(acc_cyc[i] - t0), 32'(nsl(i) + 2));
        lat = 0;
        while ((!in_ready[i] || pending[i]) && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("b2b_drain", i, 32'(in_ready[i]), 32'd1);
        out_ready[i] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        for (int i = 0; i < NDUT; i++) begin
            in_valid[i] = 1'b0; out_ready[i] = 1'b0;
            in_a[i] = '0; in_b[i] = '0; sel[i] = 1'b0; cin[i] = 1'b0;
            pending[i] = 1'b0; acc_n[i] = 0; acc_cyc[i] = 0;
        end
        in_valid[0] = 1'b1;
        in_a[0] = 16'h1234; in_b[0] = 16'h1111;
        fork
            compare_loop();
        join_none

        // Reset state, with in_valid asserted throughout reset.
        repeat (3) @(negedge clk);
        for (int i = 0; i < NDUT; i++)
            chk("reset_state", i, 32'({in_ready[i], out_valid[i], dut_res(i)}), 32'h0020_0000);
        rst = 1'b0;
        in_valid[0] = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", 0, 32'({in_ready[0], out_valid[0]}), 32'd2);

        // Pin the reference model to hand-computed values.
        chk("model_pin_add", 0, 32'(model(16'h1234, 16'h0FED, 1'b0, 1'b0)), 32'h2221_0);
        chk("model_pin_sub", 0, 32'(model(16'h8000, 16'h0001, 1'b1, 1'b0)), 32'h7FFF_C);
        chk("model_pin_neg", 0, 32'(model(16'h0005, 16'h0007, 1'b1, 1'b0)), 32'hFFFE_1);

        // Directed vectors on the default SLICE=4 instance.
        run_op(0, 16'h1234, 16'h0FED, 1'b0, 1'b0, 5, 1'b0, 1'b1, {16'h2221, 4'b0000});
        run_op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 1'b1, 1'b1, {16'h8000, 4'b0101});
        run_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1, 1'b0, 1'b1, {16'h0000, 4'b1010});
        run_op(0, 16'h0005, 16'h0007, 1'b1, 1'b0, 0, 1'b0, 1'b1, {16'hFFFE, 4'b0001});
        run_op(0, 16'h1234, 16'h1234, 1'b1, 1'b0, 0, 1'b0, 1'b1, {16'h0000, 4'b1010});
        run_op(0, 16'h8000, 16'h0001, 1'b1, 1'b0, 0, 1'b0, 1'b1, {16'h7FFF, 4'b1100});
        run_op(0, 16'h0010, 16'h0000, 1'b1, 1'b1, 0, 1'b0, 1'b1, {16'h000F, 4'b1000});
        run_op(0, 16'h00FF, 16'h0000, 1'b0, 1'b1, 0, 1'b0, 1'b1, {16'h0100, 4'b0000});

        // Reset in the middle of RUN, after two slices have been written.
        @(negedge clk);
        in_a[0] = 16'h00FF; in_b[0] = 16'h0F0F; sel[0] = 1'b0; cin[0] = 1'b0;
        in_valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_run_reset", 0, 32'({in_ready[0], out_valid[0], dut_res(0)}), 32'h0020_0000);
        rst = 1'b0;
        run_op(0, 16'h0001, 16'h0001, 1'b0, 1'b0, 0, 1'b0, 1'b1, {16'h0002, 4'b0000});

        // Back-to-back command spacing.
        b2b(0);
        b2b(1);
        b2b(3);

        // Random sweep on every slice configuration.
        for (int i = 0; i < NDUT; i++) begin
            for (int n = 0; n < 12; n++) begin
                run_op(i, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                       int'($urandom_range(0, 2)), 1'b0, 1'b0, 20'h0);
            end
        end
        run_op(1, 16'h0005, 16'h0007, 1'b1, 1'b0, 0, 1'b0, 1'b1, {16'hFFFE, 4'b0001});
        run_op(2, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0, 1'b1, {16'h8000, 4'b0101});
        run_op(3, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0, 1'b1, {16'h0000, 4'b1010});

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/addsub_slice_seq.md
# addsub_slice_seq

Parametrised, multi-cycle adder/subtractor that computes a WIDTH-bit sum or difference one SLICE-bit slice per clock, LSB slice first, rippling the carry between slices through a register. It is the sequential successor of the 4-bit mux-based add/sub stage. It trades latency for a small per-cycle carry chain, and adds a valid/ready handshake and result flags. It sits between operand-producing logic and any consumer that needs WIDTH-bit add/sub results with carry/borrow chaining.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of SLICE (elaboration error otherwise)
- SLICE, 4, bits processed per cycle; 1 ≤ SLICE ≤ WIDTH; NSLICE = WIDTH/SLICE

- clk  input  1  single clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands/command present
- in_ready  output  1  block can accept a command (high only in IDLE)
- inA  input  WIDTH  operand A
- inB  input  WIDTH  operand B
- add_sub_sel  input  1  0 = add, 1 = subtract
- c_in  input  1  carry-in (add) / borrow-in (subtract)
- out_valid  output  1  result registers valid
- out_ready  input  1  consumer accepts result
- out  output  WIDTH  result
- c_out  output  1  raw carry out of MSB
- ovf  output  1  two's-complement signed overflow
- zero  output  1  out == 0
- neg  output  1  out[WIDTH-1]

## Operation
- Arithmetic: add: out = A + B + c_in. Sub: out = A + ~B + !c_in (i.e. A − B − c_in).
- c_out is the raw carry of that sum. For sub, borrow = !c_out.
- ovf = carry into MSB XOR carry out of MSB. This is computed in the final slice.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch inA, inB, add_sub_sel, and the initial carry (c_in for add, !c_in for sub); clear the slice counter; go to RUN.
  - RUN: each cycle, add slice k of A and (B or ~B) with the carry register. Write out[k*SLICE +: SLICE], update the carry register, increment k. On k == NSLICE−1, also write c_out/ovf/zero/neg and go to DONE.
  - DONE: out_valid=1; outputs held stable. On out_ready, go to IDLE.
- Inputs are sampled only at acceptance; changes to inA/inB/add_sub_sel/c_in during RUN/DONE are ignored.
- zero is evaluated over the full WIDTH-bit result, not per slice.
- The out bus may show partial results during RUN. Consumers must qualify with out_valid.

## Timing
- Reset (rst high at a rising edge), from any state including mid-RUN: state=IDLE, in_ready=1 the following cycle, out_valid=0, out=0, c_out=0, ovf=0, zero=0, neg=0, carry register and slice counter cleared. An in-flight operation is discarded.
- in_valid during reset: ignored.
- Latency: acceptance edge E. Slices are computed at edges E+1 … E+NSLICE. out_valid is high in the cycle following edge E+NSLICE.
- Defaults: NSLICE=4, so out_valid rises 4 cycles after acceptance.
- out_valid held with all result outputs stable until the edge where out_ready=1. At that edge the block goes to IDLE and out_valid=0 next cycle.
- No pipelining/overlap: in_ready=0 in RUN and DONE. A new command is accepted no earlier than the cycle after the output handshake.
- Minimum command spacing: NSLICE+2 cycles.
- out_ready asserted early (before DONE) has no effect.
- NSLICE=1 (SLICE=WIDTH): single RUN cycle, same protocol.

## Test plan
- Add, WIDTH=16/SLICE=4: A=0x1234, B=0x0FED, sel=0, c_in=0 -> out=0x2221, c_out=0, ovf=0, zero=0, neg=0. out_valid exactly 4 cycles after accept.
- Add overflow/wrap: 0x7FFF+0x0001 -> 0x8000, ovf=1, neg=1, c_out=0. 0xFFFF+0x0001 -> 0x0000, c_out=1, zero=1, ovf=0.
- Subtract: 0x0005−0x0007, c_in=0 -> 0xFFFE, c_out=0 (borrow), neg=1. 0x1234−0x1234 -> 0x0000, zero=1, c_out=1. 0x8000−0x0001 -> 0x7FFF, ovf=1.
- Borrow/carry-in chaining: sub 0x0010−0x0000, c_in=1 -> 0x000F, c_out=1. Add 0x00FF+0x0000, c_in=1 -> 0x0100 (carry ripples across slice boundary).
- Handshake: hold out_ready=0 for 5 cycles in DONE -> out/flags stable, in_ready=0. Change inA during RUN -> result unaffected. Back-to-back commands spaced NSLICE+2 cycles.
- Reset mid-RUN after slice 2 -> next cycle IDLE, all outputs 0. A following command 0x0001+0x0001 -> 0x0002 with correct latency. Repeat the random-compare sweep for SLICE=1, 8, 16 against a reference model.
